sensors_intf_nios2_qsys_0_dtrace_packer: RTL

Upstream stage of the OCI trace test-bench monitor in the sensors_intf Nios II core. Packs 2-bit trace atoms into a 30-bit compressed trace buffer with a 4-bit fill count, exposes the live buffer/count pair (`dct_buffer`, `dct_count`), and emits completed or flushed frames over a valid/ready interface. It also sequences end-of-test: it turns a `test_ending` request into a final flush and a sticky `test_has_ended` indication.

---
 rtl/sensors_intf_nios2_qsys_0_dtrace_packer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sensors_intf_nios2_qsys_0_dtrace_packer.sv
// Packs 2-bit trace atoms into 15-slot frames with valid/ready output and an end-of-test drain.
// Optional frame parity is built only when DTRACE_PACKER_PARITY_EN is defined.
module sensors_intf_nios2_qsys_0_dtrace_packer #(
  parameter int unsigned AtomW  = 2,
  parameter int unsigned Depth  = 15,
  parameter int unsigned CountW = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   atom_valid_i,
  input  logic [AtomW-1:0]       atom_code_i,
  input  logic                   flush_i,
  input  logic                   test_ending_i,
  output logic                   frame_valid_o,
  input  logic                   frame_ready_i,
  output logic [AtomW*Depth-1:0] frame_data_o,
  output logic [CountW-1:0]      frame_count_o,
  output logic                   frame_parity_o,
  output logic [AtomW*Depth-1:0] dct_buffer_o,
  output logic [CountW-1:0]      dct_count_o,
  output logic                   overflow_o,
  output logic                   test_has_ended_o
);

  localparam int unsigned BufW = AtomW * Depth;
  localparam logic [CountW-1:0] Full = CountW'(Depth);

  logic [BufW-1:0]   buf_q, buf_d, fdata_q, fdata_d;
  logic [CountW-1:0] cnt_q, cnt_d, fcount_q, fcount_d;
  logic              fvalid_q, fvalid_d;
  logic              ovf_q, ovf_d;
  logic              pend_q, pend_d;
  logic              ending_q, ending_d;
  logic              ended_q, ended_d;
  logic              out_free, at_full, commit, atom_acc;

  always_comb begin
    out_free = !fvalid_q || frame_ready_i;
    at_full  = (cnt_q == Full);
    commit   = (at_full || (pend_q && (cnt_q != '0))) && out_free;
    // Once ending is latched, atoms are discarded without counting as overflow.
    atom_acc = atom_valid_i && !ending_q;

    buf_d    = buf_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    fvalid_d = fvalid_q;
    fdata_d  = fdata_q;
    fcount_d = fcount_q;

    if (commit) begin
      buf_d = '0;
      cnt_d = '0;
      if (atom_acc) begin
        buf_d[AtomW-1:0] = atom_code_i;
        cnt_d            = CountW'(1);
      end
      fvalid_d = 1'b1;
      fdata_d  = buf_q;
      fcount_d = cnt_q;
    end else begin
      if (atom_acc) begin
        if (!at_full) begin
          buf_d[AtomW*cnt_q +: AtomW] = atom_code_i;
          cnt_d                       = cnt_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (fvalid_q && frame_ready_i) fvalid_d = 1'b0;
    end

    // A new request wins over the clear so a flush on the commit cycle is not lost.
    if (flush_i || (test_ending_i && !ending_q)) begin
      pend_d = 1'b1;
    end else if (commit || ((cnt_q == '0) && !atom_acc)) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    ending_d = ending_q || test_ending_i;
    ended_d  = ended_q || (ending_q && (cnt_q == '0) && !pend_q && !fvalid_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q    <= '0;
      cnt_q    <= '0;
      fvalid_q <= 1'b0;
      fdata_q  <= '0;
      fcount_q <= '0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
      ending_q <= 1'b0;
      ended_q  <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      fvalid_q <= fvalid_d;
      fdata_q  <= fdata_d;
      fcount_q <= fcount_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      ending_q <= ending_d;
      ended_q  <= ended_d;
    end
  end

`ifdef DTRACE_PACKER_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = commit ? ^buf_q : par_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) par_q <= 1'b0;
    else         par_q <= par_d;
  end

  assign frame_parity_o = par_q;
`else
  assign frame_parity_o = 1'b0;
`endif

  assign frame_valid_o    = fvalid_q;
  assign frame_data_o     = fdata_q;
  assign frame_count_o    = fcount_q;
  assign dct_buffer_o     = buf_q;
  assign dct_count_o      = cnt_q;
  assign overflow_o       = ovf_q;
  assign test_has_ended_o = ended_q;

endmodule
